// File: rtl/matrix_pkg.sv
// Shared types and constants for the LED matrix scan driver.
// Build option: MATRIX_BRIGHTNESS_EN adds a 3-bit OEB duty control.
package matrix_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SHIFT,
        ST_BLANK,
        ST_LATCH,
        ST_ROWCLK,
        ST_SHOW
    } state_t;

    localparam int DEF_COLS   = 32;
    localparam int DEF_ROWS   = 16;
    localparam int DEF_HOLD_W = 8;

    function automatic int row_cycles(input int cols, input int hold_w);
        return 2 * cols + 5 + (1 << hold_w);
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter timing the SHIFT and SHOW phases.
// Under MATRIX_BRIGHTNESS_EN it also exports its next count value.
module scan_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
`ifdef MATRIX_BRIGHTNESS_EN
    output logic [W-1:0] o_count_nx,
`endif
    output logic         o_done
);

    logic [W-1:0] r_count;
    logic [W-1:0] w_count_nx;
    logic         r_active;

    always_comb begin
        w_count_nx = r_count;
        if (i_load) begin
            w_count_nx = i_load_val;
        end else if (r_count != '0) begin
            w_count_nx = r_count - 1'b1;
        end
    end

    // done fires once, on the last cycle of a loaded interval
    assign o_done = r_active && (r_count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_active <= 1'b0;
        end else begin
            r_count <= w_count_nx;
            if (i_load) begin
                r_active <= 1'b1;
            end else if (o_done) begin
                r_active <= 1'b0;
            end
        end
    end

`ifdef MATRIX_BRIGHTNESS_EN
    assign o_count_nx = w_count_nx;
`endif

endmodule

// File: rtl/matrix_scan_driver.sv
// Row-scanning driver for the LED matrix column/row shift chains.
// Build option: MATRIX_BRIGHTNESS_EN adds the brightness input.
module matrix_scan_driver
    import matrix_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int HOLD_W = DEF_HOLD_W
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    fb_rd,
    output logic [$clog2(ROWS)-1:0] fb_addr,
    input  logic [COLS-1:0]         fb_data,
`ifdef MATRIX_BRIGHTNESS_EN
    input  logic [2:0]              brightness,
`endif
    output logic                    CSDI,
    output logic                    CCLK,
    output logic                    LE,
    output logic                    RSDI,
    output logic                    RCLK,
    output logic                    OEB,
    output logic                    frame_start
);

    localparam int RW = $clog2(ROWS);
    localparam int SW = $clog2(2 * COLS);
    localparam int TW = (HOLD_W > SW) ? HOLD_W : SW;
    localparam logic [TW-1:0] LD_SHIFT = TW'(2 * COLS - 1);
    localparam logic [TW-1:0] LD_HOLD  = TW'((1 << HOLD_W) - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    state_t          r_state;
    state_t          w_state_nx;
    logic [RW-1:0]   r_row;
    logic [RW-1:0]   w_row_nx;
    logic [COLS-1:0] r_sreg;
    logic [COLS-1:0] w_sreg_nx;
    logic            w_load;
    logic [TW-1:0]   w_load_val;
    logic            w_done;
    logic            w_cclk_nx;
    logic            w_rsdi_nx;
    logic            w_lit;

`ifdef MATRIX_BRIGHTNESS_EN
    logic [TW-1:0] w_cnt_nx;
    logic [TW-1:0] w_elapsed;
    logic [TW-1:0] w_step;
    logic [2:0]    r_bright;
    logic [2:0]    w_bright_nx;

    if (HOLD_W < 3) begin : g_hold_w_check
        $error("MATRIX_BRIGHTNESS_EN needs HOLD_W >= 3");
    end
`endif

    scan_timer #(
        .W(TW)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
`ifdef MATRIX_BRIGHTNESS_EN
        .o_count_nx (w_cnt_nx),
`endif
        .o_done     (w_done)
    );

    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_load_val = LD_SHIFT;
        unique case (r_state)
            ST_IDLE:   w_state_nx = ST_FETCH;
            ST_FETCH:  w_state_nx = ST_LOAD;
            ST_LOAD: begin
                w_state_nx = ST_SHIFT;
                w_load     = 1'b1;
                w_load_val = LD_SHIFT;
            end
            ST_SHIFT: begin
                if (w_done) w_state_nx = ST_BLANK;
            end
            ST_BLANK:  w_state_nx = ST_LATCH;
            ST_LATCH:  w_state_nx = ST_ROWCLK;
            ST_ROWCLK: begin
                w_state_nx = ST_SHOW;
                w_load     = 1'b1;
                w_load_val = LD_HOLD;
            end
            ST_SHOW: begin
                if (w_done) w_state_nx = ST_FETCH;
            end
            default:   w_state_nx = ST_IDLE;
        endcase
    end

    // Outputs are registered from next-cycle values so they line up with state.
    always_comb begin
        w_row_nx = r_row;
        if (r_state == ST_SHOW && w_done) begin
            w_row_nx = (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
        end
        w_sreg_nx = r_sreg;
        if (r_state == ST_LOAD) begin
            w_sreg_nx = fb_data;
        end else if (r_state == ST_SHIFT && CCLK) begin
            w_sreg_nx = r_sreg << 1;
        end
        w_cclk_nx = (w_state_nx == ST_SHIFT) && (r_state == ST_SHIFT) && !CCLK;
        w_rsdi_nx = (r_row == '0) &&
                    ((w_state_nx == ST_BLANK) ||
                     (w_state_nx == ST_LATCH) ||
                     (w_state_nx == ST_ROWCLK));
    end

`ifdef MATRIX_BRIGHTNESS_EN
    always_comb begin
        w_bright_nx = (r_state == ST_ROWCLK) ? brightness : r_bright;
        w_elapsed   = LD_HOLD - w_cnt_nx;
        w_step      = w_elapsed >> (HOLD_W - 3);
        w_lit       = (w_step <= TW'(w_bright_nx));
    end

    always_ff @(posedge clk) begin
        if (reset) r_bright <= '0;
        else       r_bright <= w_bright_nx;
    end
`else
    assign w_lit = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_row       <= '0;
            r_sreg      <= '0;
            fb_rd       <= 1'b0;
            fb_addr     <= '0;
            CSDI        <= 1'b0;
            CCLK        <= 1'b0;
            LE          <= 1'b0;
            RSDI        <= 1'b0;
            RCLK        <= 1'b0;
            OEB         <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_row       <= w_row_nx;
            r_sreg      <= w_sreg_nx;
            fb_rd       <= (w_state_nx == ST_FETCH);
            fb_addr     <= w_row_nx;
            CSDI        <= (w_state_nx == ST_SHIFT) && w_sreg_nx[COLS-1];
            CCLK        <= w_cclk_nx;
            LE          <= (w_state_nx == ST_LATCH);
            RSDI        <= w_rsdi_nx;
            RCLK        <= (w_state_nx == ST_ROWCLK);
            OEB         <= !((w_state_nx == ST_SHOW) && w_lit);
            frame_start <= (r_state == ST_ROWCLK) && (r_row == '0);
        end
    end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed bench for matrix_scan_driver with COLS=4, ROWS=3, HOLD_W=3.
// Build with MATRIX_BRIGHTNESS_EN to also exercise the duty control.
module tb_matrix_scan_driver;
    import matrix_pkg::*;

    localparam int COLS    = 4;
    localparam int ROWS    = 3;
    localparam int HOLD_W  = 3;
    localparam int ROW_CYC = row_cycles(COLS, HOLD_W);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] fb_data = '0;
    logic [2:0] tb_bright = 3'd7;
    logic       fb_rd;
    logic [1:0] fb_addr;
    logic       CSDI, CCLK, LE, RSDI, RCLK, OEB, frame_start;

    int total = 0;
    int bad   = 0;

    matrix_scan_driver #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .HOLD_W (HOLD_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fb_rd       (fb_rd),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
`ifdef MATRIX_BRIGHTNESS_EN
        .brightness  (tb_bright),
`endif
        .CSDI        (CSDI),
        .CCLK        (CCLK),
        .LE          (LE),
        .RSDI        (RSDI),
        .RCLK        (RCLK),
        .OEB         (OEB),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] outs();
        return {fb_rd, fb_addr, CSDI, CCLK, LE, RSDI, RCLK, OEB, frame_start};
    endfunction

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Checks ncyc cycles of one row starting at its FETCH cycle.
    task automatic run_row(input int row, input logic [3:0] data, input int ncyc);
        logic [9:0] e;
        logic       csdi, cclk, lit;
        int         j;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            j    = i - 2;
            csdi = (i >= 2 && i <= 9) ? data[3 - j / 2] : 1'b0;
            cclk = (i >= 2 && i <= 9) && (j % 2 == 1);
            lit  = (i >= 13) && ((i - 13) <= int'(tb_bright));
            e = {(i == 0), 2'(row), csdi, cclk, (i == 11),
                 (row == 0) && (i >= 10 && i <= 12), (i == 12),
                 !lit, (i == 13) && (row == 0)};
            chk($sformatf("row%0d_c%0d", row, i), outs(), e);
            if (i == 0) fb_data = data;
            if (i == 2) fb_data = ~data;
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_hold", outs(), 10'b00_0000_0010);
        reset = 1'b0;

        run_row(0, 4'b1010, ROW_CYC);
        run_row(1, 4'b0110, ROW_CYC);
        run_row(2, 4'b1101, ROW_CYC);
        run_row(0, 4'b0011, ROW_CYC);

        run_row(1, 4'b1011, 5);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset", outs(), 10'b00_0000_0010);
        reset = 1'b0;
        run_row(0, 4'b1001, ROW_CYC);
        run_row(1, 4'b0101, ROW_CYC);

`ifdef MATRIX_BRIGHTNESS_EN
        tb_bright = 3'd3;
        run_row(2, 4'b1110, ROW_CYC);
        tb_bright = 3'd0;
        run_row(0, 4'b0111, ROW_CYC);
        tb_bright = 3'd7;
        run_row(1, 4'b1000, ROW_CYC);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
